// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg : shared types and defaults for the pipeline stall sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipeline_ctrl_pkg;

  localparam int DEF_MEM_TIMEOUT = 16;
  localparam int DEF_CNT_W       = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_BUSY = 2'd2
  } ctrl_state_e;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter : enabled up-counter that sticks at all-ones
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl : stall/flush sequencer for the 5-stage pipeline
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_stall_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_hz,
  input  logic             br_taken_EX,
  input  logic             dmem_req_MEM,
  input  logic             dmem_ack,
  input  logic             mdu_start_EX,
  input  logic             mdu_done,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e       state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              done_latched, done_latched_nxt;
  logic              mdu_pend, mdu_pend_nxt;

  logic ack_eff, mem_stall, done_eff, mdu_stall, timeout, mdu_exit;

  // The registered watchdog pulse doubles as the release of the timed-out access.
  assign ack_eff   = dmem_ack | mem_err;
  assign mem_stall = ((state == MEM_WAIT) || dmem_req_MEM) && !ack_eff;
  assign done_eff  = mdu_done | done_latched;
  assign mdu_stall = (state == MDU_BUSY) && !done_eff;
  assign timeout   = (state == MEM_WAIT) && !ack_eff && (wait_cnt == WAIT_LAST);
  assign mdu_exit  = (state == MDU_BUSY) && (state_nxt == RUN);

  always_comb begin
    state_nxt        = state;
    mdu_pend_nxt     = 1'b0;
    done_latched_nxt = done_latched;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt    = MEM_WAIT;
          mdu_pend_nxt = mdu_start_EX && !mdu_done;
        end else if (mdu_start_EX && !mdu_done) begin
          state_nxt = MDU_BUSY;
        end
      end
      MEM_WAIT: begin
        if (!mem_stall || timeout) begin
          state_nxt = mdu_pend ? MDU_BUSY : RUN;
        end else begin
          mdu_pend_nxt = mdu_pend;
        end
      end
      MDU_BUSY: begin
        if (mem_stall) begin
          state_nxt    = MEM_WAIT;
          mdu_pend_nxt = 1'b1;
        end else if (done_eff) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
    // A done pulse arriving while the MDU is parked behind a memory wait is kept.
    if (mdu_exit) begin
      done_latched_nxt = 1'b0;
    end else if (mdu_done && ((state == MDU_BUSY) || mdu_pend)) begin
      done_latched_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      wait_cnt     <= '0;
      done_latched <= 1'b0;
      mdu_pend     <= 1'b0;
      mem_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      done_latched <= done_latched_nxt;
      mdu_pend     <= mdu_pend_nxt;
      mem_err      <= timeout;
      if ((state == MEM_WAIT) && (state_nxt == MEM_WAIT)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (mem_stall) begin
      // MEM/WB stays enabled so the bubble is actually loaded behind the stall.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (mdu_stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_flush = 1'b1;
    end else if (br_taken_EX) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use_hz) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (!pc_write),
    .count (stall_cycles)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_ctrl : directed self-checking bench for pipeline_stall_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_stall_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int CNT_W = 5;

  // {pc, if_id_w, id_ex_w, ex_mem_w, mem_wb_w, if_id_f, id_ex_f, ex_mem_f, mem_wb_f}
  localparam logic [8:0] NORM = 9'b1_1111_0000;
  localparam logic [8:0] MEMS = 9'b0_0001_0001;
  localparam logic [8:0] MDUS = 9'b0_0011_0010;
  localparam logic [8:0] LU   = 9'b0_0111_0100;
  localparam logic [8:0] RED  = 9'b1_1111_1100;

  logic clk = 1'b0;
  logic rst;
  logic load_use_hz, br_taken_EX, dmem_req_MEM, dmem_ack, mdu_start_EX, mdu_done;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [8:0] ctrl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign ctrl = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

  pipeline_stall_ctrl #(
    .MEM_TIMEOUT (16),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_use_hz  (load_use_hz),
    .br_taken_EX  (br_taken_EX),
    .dmem_req_MEM (dmem_req_MEM),
    .dmem_ack     (dmem_ack),
    .mdu_start_EX (mdu_start_EX),
    .mdu_done     (mdu_done),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .id_ex_write  (id_ex_write),
    .ex_mem_write (ex_mem_write),
    .mem_wb_write (mem_wb_write),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_flush (ex_mem_flush),
    .mem_wb_flush (mem_wb_flush),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs just after the edge; return at the falling edge.
  task automatic cyc(input logic ld, input logic br, input logic req,
                     input logic ack, input logic ms, input logic md);
    @(posedge clk);
    #1;
    load_use_hz  = ld;
    br_taken_EX  = br;
    dmem_req_MEM = req;
    dmem_ack     = ack;
    mdu_start_EX = ms;
    mdu_done     = md;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    load_use_hz = 0; br_taken_EX = 0; dmem_req_MEM = 0;
    dmem_ack = 0; mdu_start_EX = 0; mdu_done = 0;
    #2;
    chk("rst_ctrl", 32'(ctrl), 32'(NORM));
    chk("rst_cnt", 32'(stall_cycles), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(RUN));
    @(posedge clk);
    #1 rst = 1'b0;

    // load-use
    cyc(1, 0, 0, 0, 0, 0); chk("lu_ctrl", 32'(ctrl), 32'(LU));
    cyc(0, 0, 0, 0, 0, 0); chk("lu_after", 32'(ctrl), 32'(NORM));
    chk("lu_cnt", 32'(stall_cycles), 32'd1);

    // redirect overrides load-use
    cyc(1, 1, 0, 0, 0, 0); chk("red_ctrl", 32'(ctrl), 32'(RED));
    cyc(0, 0, 0, 0, 0, 0); chk("red_cnt", 32'(stall_cycles), 32'd1);

    // memory wait, ack on the 4th cycle
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0, 0, 0); chk($sformatf("mem_wait%0d", i), 32'(ctrl), 32'(MEMS));
    end
    cyc(0, 0, 1, 1, 0, 0); chk("mem_ack", 32'(ctrl), 32'(NORM));
    cyc(0, 0, 0, 0, 0, 0); chk("mem_state", 32'(dut.state), 32'(RUN));
    chk("mem_cnt", 32'(stall_cycles), 32'd4);

    // MDU op, done 5 cycles later; redirect held through the stall
    cyc(0, 0, 0, 0, 1, 0); chk("mdu_start", 32'(ctrl), 32'(NORM));
    for (int i = 0; i < 5; i++) begin
      cyc(0, (i == 4), 0, 0, 0, 0); chk($sformatf("mdu_busy%0d", i), 32'(ctrl), 32'(MDUS));
    end
    cyc(0, 1, 0, 0, 0, 1); chk("mdu_done_red", 32'(ctrl), 32'(RED));
    cyc(0, 0, 0, 0, 0, 0); chk("mdu_after", 32'(ctrl), 32'(NORM));
    chk("mdu_state", 32'(dut.state), 32'(RUN));
    chk("mdu_cnt", 32'(stall_cycles), 32'd9);

    // mdu_done lands during a memory wait
    cyc(0, 0, 0, 0, 1, 0); chk("ml_start", 32'(ctrl), 32'(NORM));
    cyc(0, 0, 1, 0, 0, 0); chk("ml_mem0", 32'(ctrl), 32'(MEMS));
    cyc(0, 0, 1, 0, 0, 1); chk("ml_mem1", 32'(ctrl), 32'(MEMS));
    cyc(0, 0, 1, 1, 0, 0); chk("ml_ack", 32'(ctrl), 32'(NORM));
    chk("ml_latched", 32'(dut.done_latched), 32'd1);
    cyc(0, 0, 0, 0, 0, 0); chk("ml_resume", 32'(ctrl), 32'(NORM));
    chk("ml_state_mdu", 32'(dut.state), 32'(MDU_BUSY));
    cyc(0, 0, 0, 0, 0, 0); chk("ml_state_run", 32'(dut.state), 32'(RUN));
    chk("ml_unlatched", 32'(dut.done_latched), 32'd0);
    chk("ml_cnt", 32'(stall_cycles), 32'd11);

    // start and done in the same cycle stays in RUN
    cyc(0, 0, 0, 0, 1, 1); chk("sd_ctrl", 32'(ctrl), 32'(NORM));
    cyc(0, 0, 0, 0, 0, 0); chk("sd_state", 32'(dut.state), 32'(RUN));

    // watchdog: 1 RUN wait cycle + 16 MEM_WAIT cycles, then release with mem_err
    for (int i = 0; i < 17; i++) begin
      cyc(0, 0, 1, 0, 0, 0);
      chk($sformatf("wd_wait%0d", i), 32'(ctrl), 32'(MEMS));
      chk($sformatf("wd_err%0d", i), 32'(mem_err), 32'd0);
    end
    cyc(0, 0, 1, 0, 0, 0); chk("wd_release", 32'(ctrl), 32'(NORM));
    chk("wd_err", 32'(mem_err), 32'd1);
    chk("wd_state", 32'(dut.state), 32'(RUN));
    cyc(0, 0, 0, 0, 0, 0); chk("wd_err_off", 32'(mem_err), 32'd0);
    chk("wd_cnt", 32'(stall_cycles), 32'd28);

    // saturation at 31, then asynchronous reset mid-wait
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0, 0, 0); chk($sformatf("sat_wait%0d", i), 32'(ctrl), 32'(MEMS));
    end
    chk("sat_cnt", 32'(stall_cycles), 32'd31);
    @(posedge clk);
    #1;
    dmem_req_MEM = 1'b0;
    rst = 1'b1;
    #2;
    chk("rstw_ctrl", 32'(ctrl), 32'(NORM));
    chk("rstw_state", 32'(dut.state), 32'(RUN));
    chk("rstw_cnt", 32'(stall_cycles), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(0, 0, 0, 0, 0, 0); chk("post_rst", 32'(ctrl), 32'(NORM));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
